// File: rtl/fifo_pattern_detector.sv
// fifo_pattern_detector
//
// Bit-serial overlapping sequence detector that drains a synchronous FIFO.
// Each word is popped with the FIFO read-enable/empty handshake, then shifted
// MSB-first into a PAT_LEN-bit history. Each time the newest PAT_LEN bits
// equal PATTERN, match_o pulses for one cycle. The history carries over from
// one word to the next, so a pattern may straddle a word boundary.
//
// Optional feature macro: PATDET_MATCH_COUNT_EN
//   defined   : 16-bit saturating match counter drives match_count_o
//   undefined : no counter register, match_count_o is tied to zero
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   enable_i      permits new FIFO reads (a word in progress always completes)
//   clear_i       flushes bit history and match count
//   empty_i       FIFO empty flag
//   fifo_data_i   FIFO read data, valid the cycle after rd_en_o
//   rd_en_o       FIFO read enable (high only in READ)
//   match_o       one-cycle registered match pulse
//   busy_o        high whenever the FSM is not IDLE
//   match_count_o saturating match count (zero when the counter is compiled out)

module fifo_pattern_detector #(
  parameter int                 DATA_WIDTH = 8,
  parameter int                 PAT_LEN    = 4,
  parameter logic [PAT_LEN-1:0] PATTERN    = 4'b1011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  rd_en_o,
  output logic                  match_o,
  output logic                  busy_o,
  output logic [15:0]           match_count_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int HV_W  = $clog2(PAT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [HV_W-1:0]  HV_FULL  = HV_W'(PAT_LEN);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LOAD,
    SHIFT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] word;
  logic [CNT_W-1:0]      bit_cnt;
  logic [PAT_LEN-1:0]    history;
  logic [PAT_LEN-1:0]    history_next;
  logic [HV_W-1:0]       hist_valid;
  logic [HV_W-1:0]       hist_valid_next;
  logic                  can_read;
  logic                  shifting;
  logic                  last_bit;
  logic                  next_bit;
  logic                  match_next;

  assign can_read = enable_i & ~empty_i;
  assign shifting = (state == SHIFT);
  assign last_bit = (bit_cnt == LAST_BIT);

  // Bits leave the word MSB-first, so the index counts down as bit_cnt rises.
  assign next_bit = word[LAST_BIT - bit_cnt];

  assign rd_en_o = (state == READ);
  assign busy_o  = (state != IDLE);

  // Next-state logic. A read is only launched from IDLE or from the last
  // SHIFT cycle, so dropping enable_i never cuts a word short and a new
  // word can follow the previous one with no idle gap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (can_read) state_next = READ;
      READ:    state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = can_read ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // History update and match decision. A clear in the same cycle as a shift
  // wins: the incoming bit is dropped and no match can be reported. The
  // match test uses the updated history and the updated fill count, so the
  // very first full window is already eligible.
  always_comb begin
    history_next    = history;
    hist_valid_next = hist_valid;
    if (clear_i) begin
      history_next    = '0;
      hist_valid_next = '0;
    end else if (shifting) begin
      history_next = {history[PAT_LEN-2:0], next_bit};
      if (hist_valid != HV_FULL) begin
        hist_valid_next = hist_valid + 1'b1;
      end
    end
    match_next = shifting && !clear_i && (history_next == PATTERN) &&
                 (hist_valid_next == HV_FULL);
  end

  // State, datapath and registered match pulse. The word register is loaded
  // in LOAD, which is the cycle the FIFO presents the data it was asked for
  // in READ. A reset while in READ simply abandons that read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      bit_cnt    <= '0;
      history    <= '0;
      hist_valid <= '0;
      match_o    <= 1'b0;
    end else begin
      state      <= state_next;
      history    <= history_next;
      hist_valid <= hist_valid_next;
      match_o    <= match_next;
      if (state == LOAD) begin
        word    <= fifo_data_i;
        bit_cnt <= '0;
      end else if (shifting) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end
  end

`ifdef PATDET_MATCH_COUNT_EN
  logic [15:0] match_count;

  // Saturating match counter, updated on the same edge that raises match_o.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      match_count <= '0;
    end else if (match_next && (match_count != 16'hFFFF)) begin
      match_count <= match_count + 16'd1;
    end
  end

  assign match_count_o = match_count;
`else
  assign match_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_pattern_detector.sv
// tb_fifo_pattern_detector
//
// Self-checking bench for fifo_pattern_detector. A queue-based FIFO stub
// answers the detector's reads. The reference model tracks each word as a
// position within its 10-cycle slot and keeps the consumed bit stream in a
// queue; matches are found by comparing the newest PAT_LEN bits against
// the pattern.

module tb_fifo_pattern_detector;

  localparam int            DW  = 8;
  localparam int            PL  = 4;
  localparam logic [PL-1:0] PAT = 4'b1011;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_i;
  logic          clear_i;
  logic          empty_i;
  logic [DW-1:0] fifo_data_i;
  logic          rd_en_o;
  logic          match_o;
  logic          busy_o;
  logic [15:0]   match_count_o;

  fifo_pattern_detector #(
    .DATA_WIDTH(DW),
    .PAT_LEN   (PL),
    .PATTERN   (PAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .empty_i      (empty_i),
    .fifo_data_i  (fifo_data_i),
    .rd_en_o      (rd_en_o),
    .match_o      (match_o),
    .busy_o       (busy_o),
    .match_count_o(match_count_o)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            pulses = 0;
  int            rd_times[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] model_q[$];
  int            pos = 0;
  logic [DW-1:0] mword = '0;
  bit            hist_bits[$];
  logic          exp_match = 1'b0;
  int            exp_count = 0;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic window_matches();
    logic [PL-1:0] v;
    v = '0;
    if (hist_bits.size() < PL) return 1'b0;
    for (int i = 0; i < PL; i++) v = {v[PL-2:0], hist_bits[i]};
    return v == PAT;
  endfunction

  task automatic pushWord(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    model_q.push_back(w);
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model
  // at the rising edge, serve the FIFO, then check at the next falling edge.
  task automatic applyStimulus(input logic r, input logic en, input logic clr);
    logic rd_prev;
    logic emp;
    logic had_bit;
    logic bit_in;
    rst      = r;
    enable_i = en;
    clear_i  = clr;
    emp      = (fifo_q.size() == 0);
    empty_i  = emp;
    rd_prev  = rd_en_o;
    bit_in   = 1'b0;
    @(posedge clk);
    cyc++;
    if (pos == 1 && model_q.size() > 0) mword = model_q.pop_front();
    if (r) begin
      pos       = 0;
      hist_bits.delete();
      exp_match = 1'b0;
      exp_count = 0;
    end else begin
      had_bit = (pos >= 3);
      if (had_bit) bit_in = mword[DW-1-(pos-3)];
      if (pos == 0 || pos == DW + 2) pos = (en && !emp) ? 1 : 0;
      else pos++;
      if (clr) begin
        hist_bits.delete();
        exp_match = 1'b0;
        exp_count = 0;
      end else if (had_bit) begin
        hist_bits.push_back(bit_in);
        if (hist_bits.size() > PL) void'(hist_bits.pop_front());
        exp_match = window_matches();
        if (exp_match && exp_count < 65535) exp_count++;
      end else begin
        exp_match = 1'b0;
      end
    end
    #1;
    if (rd_prev === 1'b1) begin
      checkOutput("read_while_empty", 16'(emp), 16'd0);
      if (fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
    end
    @(negedge clk);
    checkOutput("rd_en", 16'(rd_en_o), 16'(pos == 1));
    checkOutput("busy", 16'(busy_o), 16'(pos != 0));
    checkOutput("match", 16'(match_o), 16'(exp_match));
`ifdef PATDET_MATCH_COUNT_EN
    checkOutput("match_count", match_count_o, 16'(exp_count));
`else
    checkOutput("match_count", match_count_o, 16'd0);
`endif
    if (match_o === 1'b1) pulses++;
    if (rd_en_o === 1'b1) rd_times.push_back(cyc);
  endtask

  task automatic runCycles(input int n, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, en, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] rich[4];
    rich[0] = 8'hB6;
    rich[1] = 8'h0B;
    rich[2] = 8'hD5;
    rich[3] = 8'h5B;
    rst         = 1'b1;
    enable_i    = 1'b0;
    clear_i     = 1'b0;
    empty_i     = 1'b1;
    fifo_data_i = '0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] single word B6, overlapping matches");
    pulses = 0;
    pushWord(8'hB6);
    runCycles(12, 1'b1);
    checkOutput("b6_pulses", 16'(pulses), 16'd2);

    $display("[TB] 05 then 80 back-to-back, straddling match");
    pulses = 0;
    rd_times.delete();
    pushWord(8'h05);
    pushWord(8'h80);
    runCycles(22, 1'b1);
    checkOutput("straddle_pulses", 16'(pulses), 16'd1);
    checkOutput("straddle_reads", 16'(rd_times.size()), 16'd2);
    if (rd_times.size() == 2)
      checkOutput("read_spacing", 16'(rd_times[1] - rd_times[0]), 16'd10);

    $display("[TB] empty held with enable high, then data arrives");
    runCycles(5, 1'b1);
    pushWord(8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rd_after_empty", 16'(rd_en_o), 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rd_one_cycle", 16'(rd_en_o), 16'd0);
    runCycles(10, 1'b1);

    $display("[TB] enable dropped mid-word");
    pulses = 0;
    rd_times.delete();
    pushWord(8'hB6);
    pushWord(8'h55);
    runCycles(5, 1'b1);
    runCycles(12, 1'b0);
    checkOutput("disable_pulses", 16'(pulses), 16'd2);
    checkOutput("disable_reads", 16'(rd_times.size()), 16'd1);
    runCycles(12, 1'b1);

    $display("[TB] reset during shift");
    pushWord(8'hB6);
    runCycles(6, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rst_busy", 16'(busy_o), 16'd0);
    pulses = 0;
    pushWord(8'hB6);
    runCycles(12, 1'b1);
    checkOutput("refeed_pulses", 16'(pulses), 16'd2);

    $display("[TB] clear during shift and while idle");
    pushWord(8'hB6);
    runCycles(5, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("count_after_clear", match_count_o, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("no_match_after_clear", 16'(match_o), 16'd0);
    runCycles(8, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) w = rich[$urandom_range(0, 3)];
        else w = DW'($urandom);
        pushWord(w);
      end
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 29) == 0);
    end
    runCycles(25, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
